// File: rtl/osc_voice_alloc_if.sv
// Note request channel between the key scanner and the voice allocator.
// valid/ready handshake; note_on and note_freq are qualified by note_valid.
interface osc_voice_alloc_if #(
    parameter int FREQ_W = 12
) ();
    logic              note_valid;
    logic              note_ready;
    logic              note_on;
    logic [FREQ_W-1:0] note_freq;

    modport master (output note_valid, note_on, note_freq, input note_ready);
    modport slave  (input note_valid, note_on, note_freq, output note_ready);
endinterface

// File: rtl/osc_voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off requests onto NUM_VOICES oscillator slots.
// Optional macro VOICE_STEAL_EN: when all voices are gated, a note-on steals the oldest voice.
module osc_voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = 12,
    parameter int AGE_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    osc_voice_alloc_if.slave             req,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic                         overflow
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              last_idx;
    logic              note_ready;
    logic              transfer;

    logic              req_on;
    logic [FREQ_W-1:0] req_freq;

    logic [FREQ_W-1:0] freq_q [NUM_VOICES];
    logic [AGE_W-1:0]  age_q  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q;

    logic              match_found, free_found, old_found;
    logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]  old_age;

    logic              do_alloc, do_steal, do_retrig, do_release, do_overflow;
    logic [IDX_W-1:0]  tgt;

    assign note_ready     = (state == IDLE);
    assign req.note_ready = note_ready;
    assign transfer       = req.note_valid && note_ready;
    assign last_idx       = (idx == IDX_W'(NUM_VOICES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (transfer) state_nxt = SCAN;
            SCAN:    if (last_idx) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture and the one-voice-per-cycle scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_on      <= 1'b0;
            req_freq    <= '0;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        req_on      <= req.note_on;
                        req_freq    <= req.note_freq;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        old_age     <= '0;
                    end
                end
                SCAN: begin
                    if (gate_q[idx] && (freq_q[idx] == req_freq) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!gate_q[idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    // Strictly-greater keeps the lowest index on equal ages.
                    if (gate_q[idx] && (!old_found || (age_q[idx] > old_age))) begin
                        old_found <= 1'b1;
                        old_idx   <= idx;
                        old_age   <= age_q[idx];
                    end
                    if (!last_idx) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Commit decision: exactly one action per request.
    always_comb begin
        do_alloc    = 1'b0;
        do_steal    = 1'b0;
        do_retrig   = 1'b0;
        do_release  = 1'b0;
        do_overflow = 1'b0;
        if (state == COMMIT) begin
            if (req_on) begin
                // A zero frequency would divide by zero in the oscillator.
                if (req_freq != '0) begin
                    if (match_found)     do_retrig = 1'b1;
                    else if (free_found) do_alloc  = 1'b1;
                    else begin
                        do_overflow = 1'b1;
`ifdef VOICE_STEAL_EN
                        do_steal    = 1'b1;
`else
                        do_steal    = 1'b0;
`endif
                    end
                end
            end else if (match_found) begin
                do_release = 1'b1;
            end
        end
    end

    always_comb begin
        tgt = old_idx;
        if (do_alloc)                     tgt = free_idx;
        else if (do_retrig || do_release) tgt = match_idx;
    end

    // NOTE: the voice arrays are reset because they drive the oscillators and mixer directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i] <= '0;
                age_q[i]  <= '0;
            end
            gate_q   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= do_overflow;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if ((do_alloc || do_steal) && gate_q[i] && (IDX_W'(i) != tgt) && (age_q[i] != '1))
                    age_q[i] <= age_q[i] + 1'b1;
            end
            if (do_alloc || do_steal) begin
                freq_q[tgt] <= req_freq;
                gate_q[tgt] <= 1'b1;
                age_q[tgt]  <= '0;
            end
            if (do_retrig)  age_q[tgt]  <= '0;
            // Frequency is kept after release so the mixer can play the tail.
            if (do_release) gate_q[tgt] <= 1'b0;
        end
    end

    always_comb begin
        voice_freq = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            voice_freq[i*FREQ_W +: FREQ_W] = freq_q[i];
    end

    assign voice_gate = gate_q;

endmodule

// File: tb/tb_osc_voice_alloc.sv
// Directed self-checking bench for osc_voice_alloc (NUM_VOICES=4).
// Expectations follow VOICE_STEAL_EN when the bench is built with that macro.
`timescale 1ns/1ps
module tb_osc_voice_alloc;
    localparam int NV     = 4;
    localparam int FREQ_W = 12;
    localparam int AGE_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NV*FREQ_W-1:0]    voice_freq;
    logic [NV-1:0]           voice_gate;
    logic                    overflow;
    int                      checks = 0;
    int                      errors = 0;

    osc_voice_alloc_if #(.FREQ_W(FREQ_W)) bus ();

    osc_voice_alloc #(.NUM_VOICES(NV), .FREQ_W(FREQ_W), .AGE_W(AGE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (bus),
        .voice_freq (voice_freq),
        .voice_gate (voice_gate),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [FREQ_W-1:0] slot(input int i);
        return voice_freq[i*FREQ_W +: FREQ_W];
    endfunction

    // Called at a negedge; returns at the first negedge with ready high again.
    task automatic request(input logic on, input logic [FREQ_W-1:0] f,
                           output int busy, output logic [NV-1:0] gate_last);
        int guard = 0;
        while (bus.note_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", 32'(guard < 50), 1);
        bus.note_valid = 1'b1;
        bus.note_on    = on;
        bus.note_freq  = f;
        @(negedge clk);
        bus.note_valid = 1'b0;
        bus.note_freq  = 12'd4095;
        busy      = 0;
        gate_last = voice_gate;
        while (bus.note_ready !== 1'b1 && busy < 50) begin
            gate_last = voice_gate;
            @(negedge clk);
            busy++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // No two gated voices may ever hold the same frequency.
    always @(negedge clk) begin
        logic dup;
        if (!rst) begin
            dup = 1'b0;
            for (int i = 0; i < NV; i++)
                for (int j = i + 1; j < NV; j++)
                    if (voice_gate[i] && voice_gate[j] && slot(i) == slot(j)) dup = 1'b1;
            check("no_dup_gated", 32'(dup), 0);
        end
    end

    initial begin
        int busy;
        logic [NV-1:0] gl;

        // Reset with a request pending: it must be ignored.
        bus.note_valid = 1'b1;
        bus.note_on    = 1'b1;
        bus.note_freq  = 12'd440;
        repeat (3) @(negedge clk);
        bus.note_valid = 1'b0;
        rst = 1'b0;
        check("rst_ready", 32'(bus.note_ready), 1);
        check("rst_gate", 32'(voice_gate), 0);
        check("rst_freq_lo", voice_freq[31:0], 0);
        check("rst_freq_hi", 32'(voice_freq[47:32]), 0);
        check("rst_overflow", 32'(overflow), 0);
        repeat (8) @(negedge clk);
        check("rst_req_ignored", 32'(voice_gate), 0);

        // First note: latency and ready timing.
        request(1'b1, 12'd440, busy, gl);
        check("t1_busy_cycles", 32'(busy), 5);
        check("t1_gate_at_T5", 32'(gl), 0);
        check("t1_gate", 32'(voice_gate), 4'b0001);
        check("t1_slot0", 32'(slot(0)), 440);
        check("t1_overflow", 32'(overflow), 0);

        // Fill, release, reallocate.
        request(1'b1, 12'd494, busy, gl);
        request(1'b1, 12'd523, busy, gl);
        request(1'b1, 12'd587, busy, gl);
        check("fill_gate", 32'(voice_gate), 4'b1111);
        check("fill_slot1", 32'(slot(1)), 494);
        check("fill_slot2", 32'(slot(2)), 523);
        check("fill_slot3", 32'(slot(3)), 587);
        request(1'b0, 12'd494, busy, gl);
        check("off_gate", 32'(voice_gate), 4'b1101);
        check("off_slot1_kept", 32'(slot(1)), 494);
        request(1'b1, 12'd659, busy, gl);
        check("realloc_gate", 32'(voice_gate), 4'b1111);
        check("realloc_slot1", 32'(slot(1)), 659);
        check("realloc_age0", 32'(dut.age_q[0]), 4);
        check("realloc_age1", 32'(dut.age_q[1]), 0);

        // All gated: overflow, optional steal of the oldest voice.
        request(1'b1, 12'd698, busy, gl);
        check("ovf_pulse", 32'(overflow), 1);
        @(negedge clk);
        check("ovf_pulse_end", 32'(overflow), 0);
        check("ovf_gate", 32'(voice_gate), 4'b1111);
`ifdef VOICE_STEAL_EN
        check("ovf_slot0", 32'(slot(0)), 698);
`else
        check("ovf_slot0", 32'(slot(0)), 440);
`endif
        check("ovf_slot1", 32'(slot(1)), 659);
        request(1'b1, 12'd740, busy, gl);
        check("ovf2_pulse", 32'(overflow), 1);
`ifdef VOICE_STEAL_EN
        check("ovf2_slot2", 32'(slot(2)), 740);
        check("ovf2_age0", 32'(dut.age_q[0]), 1);
        check("ovf2_age2", 32'(dut.age_q[2]), 0);
`else
        check("ovf2_slot2", 32'(slot(2)), 523);
        check("ovf2_age0", 32'(dut.age_q[0]), 4);
        check("ovf2_age2", 32'(dut.age_q[2]), 2);
`endif

        // Retrigger, zero frequency, absent note-off.
        do_reset();
        check("rst2_gate", 32'(voice_gate), 0);
        request(1'b1, 12'd440, busy, gl);
        request(1'b1, 12'd440, busy, gl);
        check("retrig_gate", 32'(voice_gate), 4'b0001);
        check("retrig_age0", 32'(dut.age_q[0]), 0);
        request(1'b1, 12'd494, busy, gl);
        check("retrig_pre_age0", 32'(dut.age_q[0]), 1);
        request(1'b1, 12'd440, busy, gl);
        check("retrig2_gate", 32'(voice_gate), 4'b0011);
        check("retrig2_age0", 32'(dut.age_q[0]), 0);
        check("retrig2_age1", 32'(dut.age_q[1]), 0);
        request(1'b1, 12'd0, busy, gl);
        check("zero_busy_cycles", 32'(busy), 5);
        check("zero_gate", 32'(voice_gate), 4'b0011);
        check("zero_slot2", 32'(slot(2)), 0);
        check("zero_overflow", 32'(overflow), 0);
        request(1'b0, 12'd880, busy, gl);
        check("absent_off_gate", 32'(voice_gate), 4'b0011);
        check("absent_off_slot0", 32'(slot(0)), 440);

        // Reset during SCAN discards the request.
        bus.note_valid = 1'b1;
        bus.note_on    = 1'b1;
        bus.note_freq  = 12'd523;
        @(negedge clk);
        bus.note_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gate", 32'(voice_gate), 0);
        check("midrst_slot0", 32'(slot(0)), 0);
        check("midrst_ready", 32'(bus.note_ready), 1);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_no_commit", 32'(voice_gate), 0);
        check("midrst_slot2", 32'(slot(2)), 0);

        // note_valid held high with changing freq: back-to-back acceptance every 6 cycles.
        bus.note_valid = 1'b1;
        bus.note_on    = 1'b1;
        bus.note_freq  = 12'd440;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 6) check("held_ready_c6", 32'(bus.note_ready), 1);
            if (k == 7) check("held_ready_c7", 32'(bus.note_ready), 0);
            if (k == 6) bus.note_freq = 12'd494;
            else        bus.note_freq = 12'(1000 + k);
        end
        @(negedge clk);
        bus.note_valid = 1'b0;
        check("held_ready_c12", 32'(bus.note_ready), 1);
        check("held_gate", 32'(voice_gate), 4'b0011);
        check("held_slot0", 32'(slot(0)), 440);
        check("held_slot1", 32'(slot(1)), 494);

        // Age saturation: slot 0 held while another voice is repeatedly allocated.
        do_reset();
        request(1'b1, 12'd100, busy, gl);
        for (int n = 0; n < 260; n++) begin
            request(1'b1, 12'd200, busy, gl);
            request(1'b0, 12'd200, busy, gl);
        end
        check("sat_age0", 32'(dut.age_q[0]), 255);
        check("sat_gate", 32'(voice_gate), 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
